// File: rtl/uart_prog_loader_if.sv
// RAM write path and status outputs of the UART program loader.
// The loader drives everything; cpu_top and the debug display read it.
interface uart_prog_loader_if;
   logic        ld_wr_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_w_data;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [15:0] words_loaded;

   modport master (
      output ld_wr_en, ld_addr, ld_w_data, busy, done, err, err_code, words_loaded
   );
   modport slave (
      input  ld_wr_en, ld_addr, ld_w_data, busy, done, err, err_code, words_loaded
   );
endinterface

// File: rtl/uart_prog_loader.sv
// 8N1 UART receiver feeding a framed program loader that writes 32-bit words into RAM.
// Frame: 0x55, LEN hi, LEN lo, LEN words (MSB first), XOR checksum of the data bytes.
module uart_prog_loader #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int BAUD         = 115_200,
   parameter int MAX_WORDS    = 256,
   parameter int TIMEOUT_CLKS = 10_000_000
) (
   input  logic clk_100M,
   input  logic reset_n,
   input  logic rx,
   uart_prog_loader_if.master ld
);
   localparam int CPB  = CLK_HZ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB + 1);
   localparam int TW   = $clog2(TIMEOUT_CLKS + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA, L_CHK, L_DONE, L_ERR} ld_state_t;

   logic [1:0]    sync_r;
   logic          rx_prev_r;
   logic          rx_s;
   rx_state_t     rx_state_r, rx_state_s;
   logic [CW-1:0] clk_cnt_r, clk_cnt_s;
   logic [2:0]    bit_idx_r, bit_idx_s;
   logic [7:0]    rx_sh_r, rx_sh_s;
   logic          byte_vld_s, frame_err_s;

   ld_state_t     ld_state_r, ld_state_s;
   logic [15:0]   len_r, len_full_s;
   logic [1:0]    byte_idx_r;
   logic [31:0]   word_r, word_full_s;
   logic [7:0]    xor_r;
   logic [TW-1:0] to_cnt_r;
   logic          busy_state_s, start_s, wr_s, ok_s, fail_s;
   logic [1:0]    fail_code_s;

   logic          wr_en_r, busy_r, done_r, err_r;
   logic [31:0]   addr_r, data_r;
   logic [1:0]    code_r;
   logic [15:0]   words_r;

   assign rx_s        = sync_r[1];
   assign len_full_s  = {len_r[15:8], rx_sh_r};
   assign word_full_s = {word_r[23:0], rx_sh_r};

   // Two-flop synchroniser plus previous sample for start-edge detection, idle high.
   always_ff @(posedge clk_100M or negedge reset_n) begin
      if (!reset_n) begin
         sync_r    <= 2'b11;
         rx_prev_r <= 1'b1;
      end else begin
         sync_r    <= {sync_r[0], rx};
         rx_prev_r <= sync_r[1];
      end
   end

   // Byte receiver state and bit-timing registers.
   always_ff @(posedge clk_100M or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_r <= RX_IDLE;
         clk_cnt_r  <= '0;
         bit_idx_r  <= 3'd0;
         rx_sh_r    <= 8'd0;
      end else begin
         rx_state_r <= rx_state_s;
         clk_cnt_r  <= clk_cnt_s;
         bit_idx_r  <= bit_idx_s;
         rx_sh_r    <= rx_sh_s;
      end
   end

   // Byte receiver next state: mid-bit sampling, glitch rejection and stop-bit check.
   always_comb begin
      rx_state_s  = rx_state_r;
      clk_cnt_s   = clk_cnt_r + CW'(1);
      bit_idx_s   = bit_idx_r;
      rx_sh_s     = rx_sh_r;
      byte_vld_s  = 1'b0;
      frame_err_s = 1'b0;
      case (rx_state_r)
         RX_IDLE: begin
            clk_cnt_s = '0;
            if (rx_prev_r && !rx_s) rx_state_s = RX_START;
            else                    rx_state_s = RX_IDLE;
         end
         RX_START: begin
            if (clk_cnt_r == CW'(HALF - 1)) begin
               clk_cnt_s  = '0;
               bit_idx_s  = 3'd0;
               rx_state_s = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               rx_state_s = RX_START;
            end
         end
         RX_DATA: begin
            if (clk_cnt_r == CW'(CPB - 1)) begin
               clk_cnt_s  = '0;
               rx_sh_s    = {rx_s, rx_sh_r[7:1]};
               bit_idx_s  = bit_idx_r + 3'd1;
               rx_state_s = (bit_idx_r == 3'd7) ? RX_STOP : RX_DATA;
            end else begin
               rx_state_s = RX_DATA;
            end
         end
         RX_STOP: begin
            if (clk_cnt_r == CW'(CPB - 1)) begin
               byte_vld_s  = rx_s;
               frame_err_s = !rx_s;
               rx_state_s  = RX_IDLE;
            end else begin
               rx_state_s = RX_STOP;
            end
         end
         default: rx_state_s = RX_IDLE;
      endcase
   end

   assign busy_state_s = (ld_state_r == L_LEN_HI) || (ld_state_r == L_LEN_LO) ||
                         (ld_state_r == L_DATA)   || (ld_state_r == L_CHK);

   // Loader state register.
   always_ff @(posedge clk_100M or negedge reset_n) begin
      if (!reset_n) ld_state_r <= L_IDLE;
      else          ld_state_r <= ld_state_s;
   end

   // Loader next state; frame_err outranks the timeout, a byte always restarts the timeout.
   always_comb begin
      ld_state_s  = ld_state_r;
      start_s     = 1'b0;
      wr_s        = 1'b0;
      ok_s        = 1'b0;
      fail_s      = 1'b0;
      fail_code_s = 2'd0;
      case (ld_state_r)
         L_IDLE, L_DONE, L_ERR: begin
            if (byte_vld_s && rx_sh_r == 8'h55) begin
               start_s    = 1'b1;
               ld_state_s = L_LEN_HI;
            end else begin
               ld_state_s = ld_state_r;
            end
         end
         L_LEN_HI: ld_state_s = byte_vld_s ? L_LEN_LO : L_LEN_HI;
         L_LEN_LO: begin
            if (!byte_vld_s) begin
               ld_state_s = L_LEN_LO;
            end else if (len_full_s > 16'(MAX_WORDS)) begin
               fail_s      = 1'b1;
               fail_code_s = 2'd1;
            end else if (len_full_s == 16'd0) begin
               ld_state_s = L_CHK;
            end else begin
               ld_state_s = L_DATA;
            end
         end
         L_DATA: begin
            if (byte_vld_s && byte_idx_r == 2'd3) begin
               wr_s       = 1'b1;
               ld_state_s = (words_r + 16'd1 == len_r) ? L_CHK : L_DATA;
            end else begin
               ld_state_s = L_DATA;
            end
         end
         L_CHK: begin
            if (!byte_vld_s) begin
               ld_state_s = L_CHK;
            end else if (rx_sh_r == xor_r) begin
               ok_s       = 1'b1;
               ld_state_s = L_DONE;
            end else begin
               fail_s      = 1'b1;
               fail_code_s = 2'd2;
            end
         end
         default: ld_state_s = L_IDLE;
      endcase
      if (busy_state_s && frame_err_s) begin
         fail_s      = 1'b1;
         fail_code_s = 2'd0;
      end else if (busy_state_s && !byte_vld_s && to_cnt_r == TW'(TIMEOUT_CLKS - 1)) begin
         fail_s      = 1'b1;
         fail_code_s = 2'd3;
      end else begin
         fail_s = fail_s;
      end
      if (fail_s) begin
         ld_state_s = L_ERR;
         wr_s       = 1'b0;
      end else begin
         ld_state_s = ld_state_s;
      end
   end

   // Loader datapath and registered outputs.
   always_ff @(posedge clk_100M or negedge reset_n) begin
      if (!reset_n) begin
         len_r      <= 16'd0;
         byte_idx_r <= 2'd0;
         word_r     <= 32'd0;
         xor_r      <= 8'd0;
         to_cnt_r   <= '0;
         wr_en_r    <= 1'b0;
         addr_r     <= 32'd0;
         data_r     <= 32'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         code_r     <= 2'd0;
         words_r    <= 16'd0;
      end else begin
         wr_en_r  <= wr_s;
         busy_r   <= (ld_state_s == L_LEN_HI) || (ld_state_s == L_LEN_LO) ||
                     (ld_state_s == L_DATA)   || (ld_state_s == L_CHK);
         to_cnt_r <= (busy_state_s && !byte_vld_s) ? to_cnt_r + TW'(1) : '0;
         if (start_s) begin
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            code_r     <= 2'd0;
            words_r    <= 16'd0;
            xor_r      <= 8'd0;
            byte_idx_r <= 2'd0;
         end
         if (ld_state_r == L_LEN_HI && byte_vld_s) len_r[15:8] <= rx_sh_r;
         if (ld_state_r == L_LEN_LO && byte_vld_s) len_r <= len_full_s;
         if (ld_state_r == L_DATA && byte_vld_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            word_r     <= word_full_s;
            xor_r      <= xor_r ^ rx_sh_r;
         end
         if (wr_s) begin
            addr_r  <= {14'd0, words_r, 2'b00};
            data_r  <= word_full_s;
            words_r <= words_r + 16'd1;
         end
         if (ok_s) done_r <= 1'b1;
         if (fail_s) begin
            err_r  <= 1'b1;
            code_r <= fail_code_s;
         end
      end
   end

   assign ld.ld_wr_en     = wr_en_r;
   assign ld.ld_addr      = addr_r;
   assign ld.ld_w_data    = data_r;
   assign ld.busy         = busy_r;
   assign ld.done         = done_r;
   assign ld.err          = err_r;
   assign ld.err_code     = code_r;
   assign ld.words_loaded = words_r;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed frames from the test plan plus random frames
// scored against a frame-level model of the expected RAM writes and status.
module tb_uart_prog_loader;
   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD   = 62_500;
   localparam int CPB    = CLK_HZ / BAUD;
   localparam int MAXW   = 256;
   localparam int TMO    = 2000;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic rx = 1'b1;
   int   total = 0;
   int   passed = 0;
   int   nbyte = 0;
   logic [63:0] obs_q[$];
   logic [31:0] wbuf[8];

   uart_prog_loader_if lif ();

   uart_prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_WORDS(MAXW), .TIMEOUT_CLKS(TMO)) dut (
      .clk_100M(clk), .reset_n(reset_n), .rx(rx), .ld(lif.master)
   );

   always #5 clk = ~clk;

   // Record every write strobe cycle and every accepted byte.
   always @(negedge clk) begin
      if (lif.ld_wr_en) obs_q.push_back({lif.ld_addr, lif.ld_w_data});
      if (dut.byte_vld_s) nbyte = nbyte + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(posedge clk);
      rx = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      @(negedge clk);
   endtask

   // Sends a whole frame from wbuf and checks writes/status against the frame rules.
   task automatic frame_and_check(input string tag, input int len, input bit force_chk,
                                  input logic [7:0] chk_val);
      logic [7:0]  x;
      logic [7:0]  c;
      logic [31:0] w;
      logic [15:0] l16;
      bit          good;
      x   = 8'h00;
      l16 = len[15:0];
      obs_q.delete();
      send_byte(8'h55, 1'b1);
      @(negedge clk);
      chk({tag, "_busy_sync"}, 64'(lif.busy), 64'd1);
      send_byte(l16[15:8], 1'b1);
      send_byte(l16[7:0], 1'b1);
      if (len > MAXW) begin
         settle();
         chk({tag, "_len_err"}, 64'(lif.err), 64'd1);
         chk({tag, "_len_code"}, 64'(lif.err_code), 64'd1);
         chk({tag, "_len_nowr"}, 64'(obs_q.size()), 64'd0);
         chk({tag, "_len_busy"}, 64'(lif.busy), 64'd0);
         return;
      end
      for (int i = 0; i < len; i++) begin
         w = wbuf[i];
         for (int b = 3; b >= 0; b--) begin
            send_byte(w[8*b +: 8], 1'b1);
            x = x ^ w[8*b +: 8];
         end
      end
      c = force_chk ? chk_val : x;
      good = (c == x);
      send_byte(c, 1'b1);
      settle();
      chk({tag, "_nwr"}, 64'(obs_q.size()), 64'(len));
      for (int i = 0; i < len && i < obs_q.size(); i++)
         chk({tag, "_wr"}, obs_q[i], {32'(4 * i), wbuf[i]});
      chk({tag, "_done"}, 64'(lif.done), 64'(good));
      chk({tag, "_err"}, 64'(lif.err), 64'(!good));
      chk({tag, "_code"}, 64'(lif.err_code), good ? 64'd0 : 64'd2);
      chk({tag, "_words"}, 64'(lif.words_loaded), 64'(len));
      chk({tag, "_busy"}, 64'(lif.busy), 64'd0);
   endtask

   initial begin
      int n0;
      int len;
      bit fc;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {lif.ld_wr_en, lif.busy, lif.done, lif.err, lif.err_code, lif.words_loaded},
          64'd0);
      chk("rst_bus", {lif.ld_addr, lif.ld_w_data}, 64'd0);
      reset_n = 1'b1;
      repeat (10) @(posedge clk);

      wbuf[0] = 32'h2008_0005;
      wbuf[1] = 32'hAC08_0000;
      frame_and_check("valid", 2, 1'b1, 8'h89);
      frame_and_check("badchk", 2, 1'b1, 8'h88);
      frame_and_check("toolong", 257, 1'b0, 8'h00);

      // Stop bit low on third data byte.
      obs_q.delete();
      send_byte(8'h55, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
      send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b0);
      settle();
      chk("ferr_err", 64'(lif.err), 64'd1);
      chk("ferr_code", 64'(lif.err_code), 64'd0);
      chk("ferr_nowr", 64'(obs_q.size()), 64'd0);
      chk("ferr_busy", 64'(lif.busy), 64'd0);
      n0 = nbyte;
      rx = 1'b0;
      repeat (CPB * 3 / 10) @(posedge clk);
      rx = 1'b1;
      repeat (CPB * 12) @(posedge clk);
      @(negedge clk);
      chk("glitch_nobyte", 64'(nbyte), 64'(n0));
      chk("glitch_err", 64'(lif.err), 64'd1);
      send_byte(8'h55, 1'b1);
      @(negedge clk);
      chk("resync_err", 64'(lif.err), 64'd0);
      chk("resync_busy", 64'(lif.busy), 64'd1);
      send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
      settle();
      chk("len0_done", 64'(lif.done), 64'd1);
      chk("len0_words", 64'(lif.words_loaded), 64'd0);

      // Stall mid-word.
      obs_q.delete();
      send_byte(8'h55, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
      send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
      repeat (TMO + 200) @(posedge clk);
      @(negedge clk);
      chk("tmo_err", 64'(lif.err), 64'd1);
      chk("tmo_code", 64'(lif.err_code), 64'd3);
      chk("tmo_busy", 64'(lif.busy), 64'd0);
      chk("tmo_nowr", 64'(obs_q.size()), 64'd0);

      // Asynchronous reset in the middle of word 1.
      send_byte(8'h55, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
      for (int b = 3; b >= 0; b--) send_byte(wbuf[0][8*b +: 8], 1'b1);
      send_byte(8'hAC, 1'b1); send_byte(8'h08, 1'b1);
      @(negedge clk);
      chk("mid_words", 64'(lif.words_loaded), 64'd1);
      chk("mid_busy", 64'(lif.busy), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_outs", {lif.ld_wr_en, lif.busy, lif.done, lif.err, lif.err_code, lif.words_loaded},
          64'd0);
      chk("arst_bus", {lif.ld_addr, lif.ld_w_data}, 64'd0);
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (5) @(posedge clk);
      frame_and_check("after_rst", 2, 1'b0, 8'h00);

      for (int k = 0; k < 5; k++) begin
         len = $urandom_range(0, 5);
         if ($urandom_range(0, 5) == 0) len = $urandom_range(257, 400);
         for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
         fc = ($urandom_range(0, 2) == 0);
         frame_and_check("rand", len, fc, 8'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
